// File: rtl/avv_pkg.sv
// rtl/avv_pkg.sv - shared types, defaults and config check for the AVV readout
//
// Contents:
//   avv_state_e     decimator state (IDLE, SETTLE, ACCUM)
//   AVV_OSR_DEF     default qualified samples per conversion
//   AVV_SETTLE_DEF  default qualified samples discarded before each conversion
//   avv_code_w_ok   true when a CODE_W-bit result can hold full scale (code == OSR)
package avv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2
  } avv_state_e;

  localparam int AVV_OSR_DEF    = 64;
  localparam int AVV_SETTLE_DEF = 4;

  function automatic bit avv_code_w_ok(input int osr, input int code_w);
    return (longint'(1) << code_w) > longint'(osr);
  endfunction

endpackage

// File: rtl/avv_edge_qual.sv
// rtl/avv_edge_qual.sv - sample rising-edge detect with bias/precharge masking
//
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   sample       controller sample level; a rising edge is one decision event
//   cmp          comparator decision, same clock domain
//   setup_bias   masks events while high
//   pre_chrg     masks events while high
//   ev           one-cycle qualified decision event
//   ev_cmp       comparator bit belonging to ev (taken in the same cycle)
module avv_edge_qual
  import avv_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic sample,
  input  logic cmp,
  input  logic setup_bias,
  input  logic pre_chrg,
  output logic ev,
  output logic ev_cmp
);

  logic sample_q;

  // sample_q follows sample even while masked, so an edge that occurs under
  // setup_bias is consumed there and cannot fire later when the mask drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sample_q <= 1'b0;
    else       sample_q <= sample;
  end

  assign ev     = sample & ~sample_q & ~setup_bias & ~pre_chrg;
  assign ev_cmp = cmp;

endmodule

// File: rtl/avv_readout.sv
// rtl/avv_readout.sv - AVV comparator decimator with valid/ready result port
//
// Counts ones over OSR qualified events after discarding SETTLE_N events,
// then publishes the count on code with a valid/ready handshake.
// Optional macro AVV_READOUT_AVG_EN: publish the rounded mean of the current
// and previous raw results (first result after reset/pre_chrg is unaveraged).
//
// Ports:
//   clk, reset              system clock, asynchronous active-high reset
//   sample, cmp             controller sample strobe and comparator decision
//   setup_bias              pauses conversion (events ignored, state held)
//   pre_chrg                aborts conversion, returns to IDLE
//   code, code_valid        result and its valid flag
//   code_ready              consumer accepts code
//   overrun                 sticky: a result replaced an unconsumed one
//   busy                    high in SETTLE or ACCUM
module avv_readout
  import avv_pkg::*;
#(
  parameter int OSR      = AVV_OSR_DEF,
  parameter int SETTLE_N = AVV_SETTLE_DEF,
  parameter int CODE_W   = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample,
  input  logic              cmp,
  input  logic              setup_bias,
  input  logic              pre_chrg,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              overrun,
  output logic              busy
);

  if (!avv_code_w_ok(OSR, CODE_W)) begin : g_bad_code_w
    $error("avv_readout: CODE_W too narrow for OSR");
  end

  localparam int SW = $clog2(SETTLE_N + 2);
  localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE_N);
  localparam logic [CODE_W-1:0] OSR_LAST    = CODE_W'(OSR);

  logic ev, ev_cmp;

  avv_edge_qual u_edge_qual (
    .clk        (clk),
    .reset      (reset),
    .sample     (sample),
    .cmp        (cmp),
    .setup_bias (setup_bias),
    .pre_chrg   (pre_chrg),
    .ev         (ev),
    .ev_cmp     (ev_cmp)
  );

  avv_state_e        state, state_nxt;
  logic [SW-1:0]     settle_cnt, settle_nxt;
  logic [CODE_W-1:0] samp_cnt, samp_nxt;
  logic [CODE_W-1:0] ones_cnt, ones_nxt;
  logic [CODE_W-1:0] raw;
  logic [CODE_W-1:0] pub;
  logic              done;
  logic              acc_ev;

  // Ones count including the current event; only consumed on the final event.
  assign raw = ones_cnt + CODE_W'(ev_cmp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      samp_cnt   <= '0;
      ones_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      samp_cnt   <= samp_nxt;
      ones_cnt   <= ones_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    samp_nxt   = samp_cnt;
    ones_nxt   = ones_cnt;
    done       = 1'b0;
    acc_ev     = 1'b0;

    if (pre_chrg) begin
      state_nxt  = IDLE;
      settle_nxt = '0;
      samp_nxt   = '0;
      ones_nxt   = '0;
    end else if (ev) begin
      case (state)
        // IDLE holds settle_cnt at 0, so it shares the settle counting path.
        IDLE, SETTLE: begin
          if (SETTLE_N == 0) begin
            acc_ev = 1'b1;
          end else if (settle_cnt + SW'(1) == SETTLE_LAST) begin
            state_nxt  = ACCUM;
            settle_nxt = '0;
          end else begin
            state_nxt  = SETTLE;
            settle_nxt = settle_cnt + SW'(1);
          end
        end
        ACCUM:   acc_ev = 1'b1;
        default: state_nxt = IDLE;
      endcase

      if (acc_ev) begin
        if (samp_cnt + CODE_W'(1) == OSR_LAST) begin
          done       = 1'b1;
          samp_nxt   = '0;
          ones_nxt   = '0;
          settle_nxt = '0;
          state_nxt  = (SETTLE_N == 0) ? ACCUM : SETTLE;
        end else begin
          state_nxt = ACCUM;
          samp_nxt  = samp_cnt + CODE_W'(1);
          ones_nxt  = raw;
        end
      end
    end
  end

`ifdef AVV_READOUT_AVG_EN
  logic [CODE_W-1:0] prev_raw;
  logic              prev_vld;
  logic [CODE_W:0]   avg_sum;

  assign avg_sum = {1'b0, raw} + {1'b0, prev_raw} + (CODE_W+1)'(1);
  assign pub     = prev_vld ? avg_sum[CODE_W:1] : raw;

  // pre_chrg and done never coincide because pre_chrg masks ev.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_raw <= '0;
      prev_vld <= 1'b0;
    end else if (pre_chrg) begin
      prev_vld <= 1'b0;
    end else if (done) begin
      prev_raw <= raw;
      prev_vld <= 1'b1;
    end
  end
`else
  assign pub = raw;
`endif

  // A completing result always loads; a simultaneous handshake only avoids
  // the overrun flag, code_valid stays high for the new result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code       <= '0;
      code_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (done) begin
      code       <= pub;
      code_valid <= 1'b1;
      if (code_valid && !code_ready) overrun <= 1'b1;
    end else if (code_valid && code_ready) begin
      code_valid <= 1'b0;
    end
  end

  assign busy = (state == SETTLE) | (state == ACCUM);

endmodule

// File: tb/tb_avv_readout.sv
// tb/tb_avv_readout.sv - self-checking bench for avv_readout (OSR=8, SETTLE_N=2)
module tb_avv_readout;

  localparam int OSR = 8;
  localparam int SN  = 2;
  localparam int CW  = 9;
`ifdef AVV_READOUT_AVG_EN
  localparam bit AVG_EN = 1'b1;
`else
  localparam bit AVG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          sample, cmp, setup_bias, pre_chrg, code_ready;
  logic [CW-1:0] code;
  logic          code_valid, overrun, busy;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  avv_readout #(.OSR(OSR), .SETTLE_N(SN), .CODE_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .sample     (sample),
    .cmp        (cmp),
    .setup_bias (setup_bias),
    .pre_chrg   (pre_chrg),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input int plain, input int avg);
    return AVG_EN ? avg : plain;
  endfunction

  // Behavioural model: a conversion is simply the event index within the
  // current run; indices 1..SN are discarded, SN+1..SN+OSR are summed.
  bit m_ps, m_active, m_prev_vld, e_valid, e_over;
  int m_pos, m_ones, m_prev, e_code;

  always @(posedge clk or posedge reset) begin
    bit ev, d, pv, vld, ov;
    int p, o, rv, pb, pr, ec;
    if (reset) begin
      m_ps <= 0; m_active <= 0; m_pos <= 0; m_ones <= 0;
      m_prev <= 0; m_prev_vld <= 0;
      e_code <= 0; e_valid <= 0; e_over <= 0;
    end else begin
      p = m_pos; o = m_ones; pv = m_prev_vld; pr = m_prev;
      vld = e_valid; ov = e_over; ec = e_code; d = 0; rv = 0;
      ev = sample && !m_ps && !setup_bias && !pre_chrg;
      if (pre_chrg) begin
        m_active <= 0; p = 0; o = 0; pv = 0;
      end else if (ev) begin
        m_active <= 1;
        p++;
        if (p > SN) o += int'(cmp);
        if (p == SN + OSR) begin
          d = 1; rv = o; p = 0; o = 0;
        end
      end
      if (d) begin
        pb = (AVG_EN && pv) ? (rv + pr + 1) / 2 : rv;
        if (vld && !code_ready) ov = 1;
        ec = pb; vld = 1; pr = rv; pv = 1;
      end else if (vld && code_ready) begin
        vld = 0;
      end
      m_pos <= p; m_ones <= o; m_prev <= pr; m_prev_vld <= pv;
      e_code <= ec; e_valid <= vld; e_over <= ov;
      m_ps <= sample;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("cyc_code", int'(code), e_code);
      chk("cyc_valid", int'(code_valid), int'(e_valid));
      chk("cyc_overrun", int'(overrun), int'(e_over));
      chk("cyc_busy", int'(busy), int'(m_active));
    end
  end

  // All stimulus tasks start and end at a falling edge.
  task automatic pulse(input bit c, input int hold);
    sample = 1'b1; cmp = c;
    repeat (hold) @(negedge clk);
    sample = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_events(input logic [31:0] pat, input int n);
    for (int i = 0; i < n; i++) pulse(pat[i], 1);
  endtask

  task automatic final_ev(input bit c, input int exp_code, input bit rdy);
    sample = 1'b1; cmp = c; code_ready = rdy;
    @(negedge clk);
    chk("final_valid", int'(code_valid), 1);
    chk("final_code", int'(code), exp_code);
    sample = 1'b0;
    @(negedge clk);
    chk("after_valid", int'(code_valid), rdy ? 0 : 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_code", int'(code), 0);
    chk("rst_valid", int'(code_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; sample = 0; cmp = 0; setup_bias = 0; pre_chrg = 0; code_ready = 0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    do_reset();

    // Basic: 2 discarded + 8 ones -> full scale.
    code_ready = 1'b1;
    run_events(32'h1FC, 9);
    final_ev(1'b1, 8, 1'b1);
    chk("basic_busy_resettle", int'(busy), 1);

    // Mixed: pattern 1,0,1,1,0,0,1,0 with the first accum event held 5 cycles.
    run_events(32'h0, 2);
    pulse(1'b1, 5);
    run_events(32'h26, 6);
    final_ev(1'b0, pick(4, 6), 1'b1);

    // Backpressure: two conversions unconsumed.
    code_ready = 1'b0;
    run_events(32'h1FF, 9);
    final_ev(1'b1, pick(8, 6), 1'b0);
    chk("bp_no_overrun_yet", int'(overrun), 0);
    run_events(32'h0, 9);
    final_ev(1'b0, pick(0, 4), 1'b0);
    chk("bp_overrun", int'(overrun), 1);
    code_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain_valid", int'(code_valid), 0);
    chk("bp_overrun_sticky", int'(overrun), 1);

    // Abort after the 5th accum event.
    run_events(32'h7C, 7);
    pre_chrg = 1'b1;
    @(negedge clk);
    pre_chrg = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_code_kept", int'(code), pick(0, 4));
    @(negedge clk);

    // Pause: 3 edges under setup_bias are ignored.
    run_events(32'h1C, 5);
    setup_bias = 1'b1;
    run_events(32'h7, 3);
    setup_bias = 1'b0;
    chk("pause_busy_held", int'(busy), 1);
    run_events(32'h0, 4);
    final_ev(1'b0, 3, 1'b1);

    // Handshake coinciding with completion.
    do_reset();
    code_ready = 1'b0;
    run_events(32'h1FF, 9);
    final_ev(1'b1, 8, 1'b0);
    run_events(32'h3C, 9);
    final_ev(1'b1, pick(5, 7), 1'b1);
    chk("simul_no_overrun", int'(overrun), 0);

    // Averaging sequence (raw results in the default build).
    do_reset();
    code_ready = 1'b1;
    run_events(32'h1FF, 9);
    final_ev(1'b1, 8, 1'b1);
    run_events(32'h1C, 9);
    final_ev(1'b0, pick(3, 6), 1'b1);
    run_events(32'h1C, 5);
    do_reset();
    run_events(32'h0C, 9);
    final_ev(1'b0, 2, 1'b1);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
